// File: rtl/result_bus_arbiter3.sv
// Three-way round-robin arbiter feeding one registered 128-bit result stage.
// The stage drains and reloads in the same cycle, so a steady stream gets one word per clock.
module result_bus_arbiter3 #(
    parameter int WIDTH = 128,
    parameter int TAG_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       req_valid,
    output logic [2:0]       req_ready,
    input  logic [WIDTH-1:0] req_data0,
    input  logic [WIDTH-1:0] req_data1,
    input  logic [WIDTH-1:0] req_data2,
    input  logic [TAG_W-1:0] req_tag0,
    input  logic [TAG_W-1:0] req_tag1,
    input  logic [TAG_W-1:0] req_tag2,
    output logic [1:0]       mux_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic [1:0]       out_src
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state, state_nxt;
    logic [1:0]       prio, prio_nxt;
    logic [1:0]       cand1, cand2, winner;
    logic             load_en, grant;
    logic [WIDTH-1:0] sel_data;
    logic [TAG_W-1:0] sel_tag;

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    assign out_valid = (state == FULL);
    assign load_en   = !out_valid || out_ready;
    assign cand1     = inc3(prio);
    assign cand2     = inc3(cand1);

    // NOTE: every variable gets a default first so no path can infer a latch.
    always_comb begin
        winner    = prio;
        grant     = 1'b0;
        req_ready = 3'b000;
        mux_sel   = 2'd0;
        prio_nxt  = prio;
        state_nxt = state;
        if (req_valid[prio])       winner = prio;
        else if (req_valid[cand1]) winner = cand1;
        else if (req_valid[cand2]) winner = cand2;
        // Gating with rst_n keeps the request side quiet while reset is held.
        grant = rst_n && load_en && (req_valid != 3'b000);
        if (grant) begin
            req_ready = 3'b001 << winner;
            mux_sel   = winner;
            prio_nxt  = inc3(winner);
            state_nxt = FULL;
        end else if (out_ready) begin
            state_nxt = EMPTY;
        end
    end

    // The 3-to-1 result mux steered by the winner.
    always_comb begin
        sel_data = req_data0;
        sel_tag  = req_tag0;
        case (winner)
            2'd1: begin sel_data = req_data1; sel_tag = req_tag1; end
            2'd2: begin sel_data = req_data2; sel_tag = req_tag2; end
            default: begin sel_data = req_data0; sel_tag = req_tag0; end
        endcase
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            prio  <= 2'd0;
        end else begin
            state <= state_nxt;
            prio  <= prio_nxt;
        end
    end

    // NOTE: the datapath register is reset too, since zero outputs are visible after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_tag  <= '0;
            out_src  <= 2'd0;
        end else if (grant) begin
            out_data <= sel_data;
            out_tag  <= sel_tag;
            out_src  <= winner;
        end
    end

endmodule

// File: tb/tb_result_bus_arbiter3.sv
// Directed bench for result_bus_arbiter3 with hand-computed expectations.
module tb_result_bus_arbiter3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   req_valid;
    logic [2:0]   req_ready;
    logic [127:0] req_data0, req_data1, req_data2;
    logic [6:0]   req_tag0, req_tag1, req_tag2;
    logic [1:0]   mux_sel;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [6:0]   out_tag;
    logic [1:0]   out_src;

    int checks   = 0;
    int failures = 0;

    result_bus_arbiter3 #(.WIDTH(128), .TAG_W(7)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data0(req_data0), .req_data1(req_data1), .req_data2(req_data2),
        .req_tag0(req_tag0), .req_tag1(req_tag1), .req_tag2(req_tag2),
        .mux_sel(mux_sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag), .out_src(out_src)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [1:0] src,
                             input logic [127:0] data, input logic [6:0] tg);
        check({tag, ".valid"}, 128'(out_valid), 128'(v));
        check({tag, ".src"},   128'(out_src),   128'(src));
        check({tag, ".data"},  out_data,        data);
        check({tag, ".tag"},   128'(out_tag),   128'(tg));
    endtask

    task automatic check_req(input string tag, input logic [2:0] rdy, input logic [1:0] sel);
        check({tag, ".ready"},   128'(req_ready), 128'(rdy));
        check({tag, ".mux_sel"}, 128'(mux_sel),   128'(sel));
    endtask

    logic [127:0] dv [3];
    logic [6:0]   tv [3];
    logic [127:0] hold_word;
    logic [1:0]   exp_src;
    int           accepted;
    int           delivered;

    initial begin
        dv[0] = {4{32'hA0A0_0001}};
        dv[1] = {4{32'hB1B1_0002}};
        dv[2] = {4{32'hC2C2_0003}};
        tv[0] = 7'h10;
        tv[1] = 7'h21;
        tv[2] = 7'h32;
        req_data0 = dv[0]; req_data1 = dv[1]; req_data2 = dv[2];
        req_tag0  = tv[0]; req_tag1  = tv[1]; req_tag2  = tv[2];
        rst_n = 1'b0;
        req_valid = 3'b000;
        out_ready = 1'b0;

        // Reset held while inputs toggle.
        for (int i = 0; i < 4; i++) begin
            req_valid = 3'(i + 5);
            out_ready = i[0];
            tick();
            check_out("rst_hold", 1'b0, 2'd0, 128'd0, 7'd0);
            check_req("rst_hold", 3'b000, 2'd0);
        end

        // Round-robin with all three valid.
        req_valid = 3'b111;
        out_ready = 1'b1;
        #1;
        rst_n = 1'b1;
        #1;
        check_req("rr_first", 3'b001, 2'd0);
        for (int i = 0; i < 6; i++) begin
            exp_src = 2'(i % 3);
            tick();
            check_out($sformatf("rr%0d", i), 1'b1, exp_src, dv[exp_src], tv[exp_src]);
        end

        // Backpressure: stage holds requester 2's word, prio is back at 0.
        out_ready = 1'b0;
        #1;
        check_req("bp_comb", 3'b000, 2'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_out($sformatf("bp%0d", i), 1'b1, 2'd2, dv[2], tv[2]);
            check_req($sformatf("bp%0d", i), 3'b000, 2'd0);
        end
        out_ready = 1'b1;
        #1;
        check_req("bp_release", 3'b001, 2'd0);
        tick();
        check_out("bp_reload", 1'b1, 2'd0, dv[0], tv[0]);

        // Steer prio to 0, then a lone requester 2, then 3'b011.
        req_valid = 3'b010;
        tick();
        req_valid = 3'b100;
        tick();
        check_out("steer", 1'b1, 2'd2, dv[2], tv[2]);
        #1;
        check_req("sparse2", 3'b100, 2'd2);
        tick();
        check_out("sparse2", 1'b1, 2'd2, dv[2], tv[2]);
        req_valid = 3'b011;
        #1;
        check_req("sparse011", 3'b001, 2'd0);
        tick();
        check_out("sparse011", 1'b1, 2'd0, dv[0], tv[0]);

        // Single word then drain to empty.
        req_data1 = 128'hDEAD_0000_0000_0000_0000_0000_0000_BEEF;
        req_tag1  = 7'h55;
        req_valid = 3'b010;
        tick();
        check_out("drain_word", 1'b1, 2'd1, 128'hDEAD_0000_0000_0000_0000_0000_0000_BEEF, 7'h55);
        req_valid = 3'b000;
        tick();
        check("drain_empty1", 128'(out_valid), 128'd0);
        tick();
        check("drain_empty2", 128'(out_valid), 128'd0);
        req_data1 = dv[1];
        req_tag1  = tv[1];

        // Reset asserted mid-FULL, away from the clock edge.
        req_valid = 3'b001;
        tick();
        check("pre_rst_full", 128'(out_valid), 128'd1);
        out_ready = 1'b0;
        req_valid = 3'b000;
        #1;
        rst_n = 1'b0;
        #1;
        check_out("rst_mid", 1'b0, 2'd0, 128'd0, 7'd0);
        check_req("rst_mid", 3'b000, 2'd0);
        rst_n = 1'b1;
        req_valid = 3'b111;
        out_ready = 1'b1;
        #1;
        check_req("post_rst", 3'b001, 2'd0);
        tick();
        check_out("post_rst", 1'b1, 2'd0, dv[0], tv[0]);

        // Requester 0 holds its word while losing to 1 then 2 (prio is 1).
        hold_word = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        req_data0 = hold_word;
        accepted  = 0;
        delivered = 0;
        for (int i = 0; i < 3; i++) begin
            exp_src = (i == 2) ? 2'd0 : 2'(i + 1);
            #1;
            if (req_ready != 3'b000) accepted++;
            check_req($sformatf("hold_req%0d", i), 3'b001 << exp_src, exp_src);
            tick();
            if (out_valid && out_ready) delivered++;
            check_out($sformatf("hold%0d", i), 1'b1, exp_src,
                      (exp_src == 2'd0) ? hold_word : dv[exp_src], tv[exp_src]);
        end
        req_valid = 3'b000;
        tick();
        check("hold_empty", 128'(out_valid), 128'd0);
        check("hold_count_acc", 128'(accepted), 128'd3);
        check("hold_count_del", 128'(delivered), 128'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/result_bus_arbiter3.md
# result_bus_arbiter3

Round-robin arbiter and output register for one shared 128-bit result/writeback bus with three producers: requester 0 = even pipe, 1 = odd pipe, 2 = local-store load path. Each cycle it picks at most one valid requester and drives the 2-bit select for the 3-to-1 128-bit result mux. It registers the winning word, tag and source into a single output stage with a valid/ready handshake toward the register-file write port.

## Interface
- WIDTH, 128, data width of each requester word and of out_data.
- TAG_W, 7, destination-register tag width (128-entry register file).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  3  bit i = requester i presents a word.
- req_ready  output  3  bit i = word i accepted this cycle (one-hot or zero).
- req_data0 / req_data1 / req_data2  input  WIDTH  requester words.
- req_tag0 / req_tag1 / req_tag2  input  TAG_W  requester destination tags.
- mux_sel  output  2  combinational select of the current winner (0/1/2); 0 when no grant.
- out_valid  output  1  output stage holds a word.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  WIDTH  registered winning word.
- out_tag  output  TAG_W  registered winning tag.
- out_src  output  2  registered index of the winning requester.

## Operation
- Output stage has two states. EMPTY: out_valid=0. FULL: out_valid=1.
- load_en = !out_valid | out_ready. The stage may accept a new word when it is empty or when it drains in the same cycle.
- Priority pointer prio ∈ {0,1,2}. Search order is prio, prio+1, prio+2 (mod 3). The winner is the first requester in that order with req_valid set.
- Grant occurs when load_en=1 and any req_valid bit is set:
  - req_ready[winner]=1 and all other bits are 0.
  - out_data/out_tag/out_src load the winner's data, tag and index.
  - prio ← (winner+1) mod 3.
  - Stage becomes or remains FULL.
- No grant when load_en=0, or when req_valid=0. In that case req_ready=0 and prio holds.
- FULL with out_ready=1 and no grant → EMPTY.
- FULL with out_ready=0 → out_data/out_tag/out_src hold stable and req_ready=0 (backpressure).
- Handshake rules:
  - req_ready may depend on req_valid.
  - A requester must hold its data and tag while req_valid=1 and req_ready=0.
  - The consumer must not make out_ready depend on anything other than out_valid.
- mux_sel = winner index when granting, else 2'd0. The value 2'd3 is never driven.
- Arithmetic: the prio increment wraps 2→0. No other counters.

## Timing
- Reset values (asserted asynchronously, immediately on rst_n low): out_valid=0, out_data=0, out_tag=0, out_src=0, prio=0, req_ready=0.
- Reset mid-transfer: any word held in the output stage is discarded. out_valid drops without waiting for the clock. After deassertion the block starts in EMPTY with prio=0.
- Latency: a word granted at edge N appears on out_data with out_valid=1 after edge N (one cycle).
- Throughput: one word per cycle when out_ready is held high. Drain and load in the same cycle is required and causes no bubble.
- Fairness: with all three requesters continuously valid and out_ready=1, grants cycle 0,1,2,0,… Any valid requester is granted within 3 grants.
- Simultaneous events:
  - Requests while FULL and stalled are not granted, and prio does not advance.
  - A lone requester is granted every cycle regardless of prio.
- req_ready and mux_sel are combinational from req_valid, prio, out_valid and out_ready. All other outputs are registered.

## Test plan
- Reset: hold rst_n=0 with all inputs toggling, then assert rst_n low mid-FULL. Required: all outputs zero immediately; first grant after release goes to requester 0 when all three are valid.
- Round-robin: req_valid=3'b111 continuously, out_ready=1, distinct data per requester. Required: out_src sequence 0,1,2,0,1,2; one word per cycle; tags match their sources.
- Backpressure: out_ready=0 for 4 cycles with requests pending. Required: out_data/out_tag/out_src are frozen, req_ready=0, prio unchanged. When out_ready returns to 1, drain and the next grant occur in the same cycle.
- Sparse requests: only requester 2 valid, with prio=0. Required: requester 2 is granted and prio becomes 0. Then 3'b011 → requester 0 is granted.
- Drain to empty: single word 128'hDEAD…BEEF with tag 7'h55, then no requests and out_ready=1. Required: out_valid=1 for exactly one cycle with those values, then 0.
- Hold-data check: a requester keeps req_valid high while losing arbitration for 2 cycles. Required: its word is delivered intact once granted, and no word is duplicated or dropped (scoreboard count equals accepted handshakes).
